bus_capture_fifo: RTL and testbench

- Reader end of the shared tristate byte bus driven by octal output registers.
- Samples the bus on an active-low strobe and queues captured words in a small FIFO.
- Presents the queued words to a downstream consumer over a valid/ready handshake.
- Lets slow consumers (console/debug interface) collect bus traffic without missing strobes.

---
 rtl/bus_capture_fifo.sv | 113 +++++++++++
 tb/tb_bus_capture_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bus_capture_fifo.sv
// bus_capture_fifo
//   Reader end of the shared tristate byte bus. Each falling strobe (STB_N
//   high->low) captures BUS into a small FIFO. The FIFO is drained by a
//   downstream consumer over a valid/ready handshake. A capture that finds
//   the FIFO full, with no pop in the same cycle, is dropped and sets the
//   sticky OVF flag.
//
// Ports
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   BUS      shared bus (pull-up terminated, so undriven bits read as 1)
//   STB_N    active-low strobe, synchronous to CLK
//   DOUT     head-of-FIFO word (combinational from storage)
//   DVALID   DOUT valid (COUNT != 0)
//   DREADY   consumer takes DOUT this cycle
//   COUNT    words held, 0..DEPTH
//   FULL     COUNT == DEPTH
//   EMPTY    COUNT == 0
//   OVF      sticky overflow flag
//   OVF_CLR  synchronous clear for OVF (a same-cycle set wins)
module bus_capture_fifo #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 3
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [WIDTH-1:0]   BUS,
  input  logic               STB_N,
  output logic [WIDTH-1:0]   DOUT,
  output logic               DVALID,
  input  logic               DREADY,
  output logic [COUNT_W-1:0] COUNT,
  output logic               FULL,
  output logic               EMPTY,
  output logic               OVF,
  input  logic               OVF_CLR
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wptr_q, wptr_d;
  logic [PTR_W-1:0]            rptr_q, rptr_d;
  logic [COUNT_W-1:0]          count_q, count_d;
  logic                        stb_hist_q, stb_hist_d;
  logic                        ovf_q, ovf_d;

  logic full, empty, capture, pop, push, drop;

  always_comb begin
    full    = (count_q == COUNT_W'(DEPTH));
    empty   = (count_q == '0);
    // Edge detect: the history flop resets to 0, so a strobe already low at
    // reset release has to go high and fall again before it is captured.
    capture = ~STB_N & stb_hist_q;
    pop     = ~empty & DREADY;
    // When full, a pop in the same cycle frees the slot the push lands in.
    push    = capture & (~full | pop);
    drop    = capture & full & ~pop;
  end

  always_comb begin
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    stb_hist_d = STB_N;
    ovf_d      = ovf_q;

    if (push) begin
      mem_d[wptr_q] = BUS;
      wptr_d        = wptr_q + PTR_W'(1);
    end
    if (pop) rptr_d = rptr_q + PTR_W'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + COUNT_W'(1);
      2'b01:   count_d = count_q - COUNT_W'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear so that no overflow goes unreported.
    if (drop)         ovf_d = 1'b1;
    else if (OVF_CLR) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      stb_hist_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      stb_hist_q <= stb_hist_d;
      ovf_q      <= ovf_d;
    end
  end

  assign DOUT   = mem_q[rptr_q];
  assign DVALID = ~empty;
  assign COUNT  = count_q;
  assign FULL   = full;
  assign EMPTY  = empty;
  assign OVF    = ovf_q;

endmodule

// File: tb/tb_bus_capture_fifo.sv
// Directed bench for bus_capture_fifo (WIDTH=8, DEPTH=4, COUNT_W=3).
// Inputs change 1 time unit after a rising edge and outputs are checked
// at that point, well away from the next edge.
module tb_bus_capture_fifo;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       STB_N;
  logic       DREADY;
  logic       OVF_CLR;
  logic [7:0] DOUT;
  logic       DVALID;
  logic [2:0] COUNT;
  logic       FULL, EMPTY, OVF;

  // Pull-up terminated bus: bits with bus_oe=0 float and read as 1.
  logic [7:0] bus_drv;
  logic [7:0] bus_oe;
  wire  [7:0] bus_w;
  for (genvar i = 0; i < 8; i++) begin : g_bus
    assign bus_w[i] = bus_oe[i] ? bus_drv[i] : 1'bz;
    pullup (bus_w[i]);
  end

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  bus_capture_fifo #(.WIDTH(8), .DEPTH(4), .COUNT_W(3)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .BUS(bus_w), .STB_N(STB_N),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .COUNT(COUNT),
    .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .OVF_CLR(OVF_CLR)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One strobe at the minimum period: low one cycle, high one cycle.
  task automatic strobe(input logic [7:0] d);
    bus_drv = d;
    STB_N   = 1'b0;
    tick();
    STB_N   = 1'b1;
    tick();
  endtask

  initial begin
    RESET_N = 1'b0; STB_N = 1'b1; DREADY = 1'b0; OVF_CLR = 1'b0;
    bus_oe  = 8'hFF; bus_drv = 8'h00;
    tick(); tick();
    chk("rst_count",  COUNT,  0);
    chk("rst_empty",  EMPTY,  1);
    chk("rst_full",   FULL,   0);
    chk("rst_dvalid", DVALID, 0);
    chk("rst_ovf",    OVF,    0);
    chk("rst_dout",   DOUT,   0);

    RESET_N = 1'b1;
    tick(); tick();
    chk("idle_count", COUNT, 0);
    chk("idle_empty", EMPTY, 1);
    chk("idle_dout",  DOUT,  0);

    // Long strobe: one capture only, visible right after the first low edge.
    bus_drv = 8'hA5; STB_N = 1'b0;
    tick();
    chk("long_lat_dvalid", DVALID, 1);
    chk("long_lat_dout",   DOUT,   8'hA5);
    chk("long_lat_count",  COUNT,  1);
    tick(); tick();
    chk("long_once_count", COUNT, 1);
    STB_N = 1'b1; tick();
    DREADY = 1'b1; tick(); DREADY = 1'b0;
    chk("long_drain", COUNT, 0);

    // Fill, then overflow with FF.
    for (int i = 1; i <= 4; i++) strobe(8'(i));
    chk("fill_full",  FULL,  1);
    chk("fill_count", COUNT, 4);
    chk("fill_ovf",   OVF,   0);
    strobe(8'hFF);
    chk("ovf_set",   OVF,   1);
    chk("ovf_count", COUNT, 4);
    chk("ovf_head",  DOUT,  8'h01);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_order", DOUT, i);
      DREADY = 1'b1; tick();
    end
    DREADY = 1'b0;
    chk("ovf_empty",  EMPTY,  1);
    chk("ovf_dvalid", DVALID, 0);
    chk("ovf_sticky", OVF,    1);

    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    chk("ovf_clr", OVF, 0);

    // Full FIFO: capture and pop in the same cycle -> no overflow.
    strobe(8'h11); strobe(8'h22); strobe(8'h33); strobe(8'h44);
    bus_drv = 8'h55; STB_N = 1'b0; DREADY = 1'b1;
    tick();
    STB_N = 1'b1; DREADY = 1'b0;
    chk("pp_count", COUNT, 4);
    chk("pp_ovf",   OVF,   0);
    chk("pp_head",  DOUT,  8'h22);
    tick();
    // Overflow and clear in the same cycle: set wins, storage untouched.
    bus_drv = 8'hEE; STB_N = 1'b0; OVF_CLR = 1'b1;
    tick();
    STB_N = 1'b1; OVF_CLR = 1'b0;
    chk("setwin_ovf",   OVF,   1);
    chk("setwin_count", COUNT, 4);
    chk("setwin_head",  DOUT,  8'h22);
    for (int i = 0; i < 4; i++) begin
      chk("pp_order", DOUT, (i == 3) ? 32'h55 : 32'h22 + 32'h11 * i);
      DREADY = 1'b1; tick();
    end
    DREADY = 1'b0;
    chk("pp_empty", EMPTY, 1);
    OVF_CLR = 1'b1; tick(); OVF_CLR = 1'b0;
    chk("pp_ovf_clr", OVF, 0);

    // Floating high nibble reads as 1s.
    bus_oe = 8'h0F; bus_drv = 8'h05; STB_N = 1'b0;
    tick();
    STB_N = 1'b1;
    chk("z_dout", DOUT, 8'hF5);
    bus_oe = 8'hFF; tick();
    DREADY = 1'b1; tick(); DREADY = 1'b0;
    chk("z_drain", EMPTY, 1);

    // Interleaved push/pop, pointers wrap more than once.
    for (int i = 0; i < 10; i++) begin
      bus_drv = 8'h10 + 8'(i); STB_N = 1'b0;
      tick();
      chk("wrap_dout",  DOUT,  32'h10 + i);
      chk("wrap_count", COUNT, 1);
      STB_N = 1'b1; DREADY = 1'b1;
      tick();
      DREADY = 1'b0;
    end
    chk("wrap_empty", EMPTY, 1);

    // Strobe held low across reset: queued words discarded, no capture
    // until STB_N goes high then low again.
    strobe(8'h66); strobe(8'h77);
    chk("pre_rst_count", COUNT, 2);
    bus_drv = 8'h88; STB_N = 1'b0; RESET_N = 1'b0;
    #1;
    chk("async_rst_count", COUNT, 0);
    tick(); tick();
    RESET_N = 1'b1;
    tick(); tick(); tick();
    chk("held_count", COUNT, 0);
    chk("held_empty", EMPTY, 1);
    chk("held_ovf",   OVF,   0);
    STB_N = 1'b1; tick();
    bus_drv = 8'h99; STB_N = 1'b0; tick();
    STB_N = 1'b1;
    chk("rearm_count", COUNT, 1);
    chk("rearm_dout",  DOUT,  8'h99);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
